// File: rtl/alu_pkg.sv
// Shared op-code and driver state definitions for the ALU driver and other MiniMIPS control blocks.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_XOR  = 3'b001,
    OP_SUB  = 3'b010,
    OP_MULT = 3'b011,
    OP_SLT  = 3'b100,
    OP_NOR  = 3'b101,
    OP_AND  = 3'b110,
    OP_OR   = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_MULT = 2'd2,
    S_RESP = 2'd3
  } drv_state_e;

endpackage

// File: rtl/alu_mult_seq.sv
// Sequential shift-add multiplier: one partial product per cycle for 32 cycles after a start pulse.
module alu_mult_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_product
);

  logic [XLEN-1:0] r_mcand;
  logic [XLEN-1:0] r_mplier;
  logic [XLEN-1:0] r_acc;
  logic [4:0]      r_cnt;
  logic            r_run;
  logic [XLEN-1:0] w_addend;
  logic [XLEN-1:0] w_acc_next;

  assign w_addend   = r_mplier[0] ? r_mcand : '0;
  assign w_acc_next = r_acc + w_addend;

  // Done is raised during the final step so the driver captures the product on the same edge.
  assign o_done    = r_run && (r_cnt == 5'd31);
  assign o_product = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= i_a;
      r_mplier <= i_b;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 5'd1;
      if (r_cnt == 5'd31) r_run <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_driver.sv
// Request/response front end for an external combinational ALU, with multiply done locally.
// state  | meaning
// S_IDLE | ready for a request
// S_EXEC | external ALU driven, result captured at end of cycle
// S_MULT | shift-add multiply running (32 cycles)
// S_RESP | result held until consumer takes it
module alu_driver
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_s,
  input  logic [XLEN-1:0] alu_r,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic            busy
);

  drv_state_e      r_state;
  logic [XLEN-1:0] r_alu_a;
  logic [XLEN-1:0] r_alu_b;
  logic [2:0]      r_alu_s;
  logic [XLEN-1:0] r_rsp_data;
  logic            r_rsp_valid;
  logic            w_accept;
  logic            w_mult_start;
  logic            w_mult_done;
  logic [XLEN-1:0] w_product;

  // Ready drops combinationally with reset so nothing is accepted while it is held.
  assign req_ready    = (r_state == S_IDLE) && rst_n;
  assign busy         = (r_state != S_IDLE);
  assign w_accept     = req_valid && req_ready;
  assign w_mult_start = w_accept && (req_op == OP_MULT);

  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_s     = r_alu_s;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;

  alu_mult_seq #(.XLEN(XLEN)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mult_start),
    .i_a       (req_a),
    .i_b       (req_b),
    .o_done    (w_mult_done),
    .o_product (w_product)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_s     <= OP_ADD;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_alu_a <= req_a;
            r_alu_b <= req_b;
            if (req_op == OP_MULT) begin
              r_state <= S_MULT;
            end else begin
              r_alu_s <= req_op;
              r_state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          r_rsp_data  <= alu_r;
          r_rsp_valid <= 1'b1;
          r_alu_s     <= OP_ADD;
          r_state     <= S_RESP;
        end
        S_MULT: begin
          if (w_mult_done) begin
            r_rsp_data  <= w_product;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
